md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs (forwarded rs/rt operands plus a decoded md_op) and runs multi-cycle mult/div/madd/msub operations.
- Owns the HI/LO registers and exposes busy so the hazard unit can stall mfhi/mflo and md instructions in ID.

---
 rtl/md_unit.sv | 126 ++++++++++++
 tb/tb_md_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and computes mult/div/madd/msub
// at the start edge, then holds busy for a fixed cycle count before committing.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, next_state;
    logic [CW-1:0] counter;
    logic [31:0]   hi_next, lo_next;
    logic          launch;
    logic [63:0]   result;
    logic [CW-1:0] launch_cycles;
    logic signed [63:0] prod_s;
    logic [63:0]   prod_u;
    logic signed [63:0] quo_s, rem_s;
    logic [63:0]   acc;

    // start is a single-cycle qualifier: an md_op is accepted only when start is high
    // in IDLE; anything presented while BUSY is dropped (the hazard unit prevents it).
    assign busy = (state == BUSY);
    assign acc  = {hi, lo};

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};
        quo_s  = '0;
        rem_s  = '0;
        // 64-bit sign-extended divide so 0x80000000 / -1 wraps to 0x80000000 cleanly
        if (B != 32'd0) begin
            quo_s = $signed({{32{A[31]}}, A}) / $signed({{32{B[31]}}, B});
            rem_s = $signed({{32{A[31]}}, A}) % $signed({{32{B[31]}}, B});
        end
        result        = acc;
        launch_cycles = CW'(MULT_CYCLES);
        case (md_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                launch_cycles = CW'(DIV_CYCLES);
                if (B != 32'd0) result = {rem_s[31:0], quo_s[31:0]};
            end
            OP_DIVU: begin
                launch_cycles = CW'(DIV_CYCLES);
                if (B != 32'd0) result = {A % B, A / B};
            end
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            OP_MSUB:  result = acc - prod_s;
            OP_MSUBU: result = acc - prod_u;
            default:  result = acc;
        endcase
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (start && md_op >= OP_MULT && md_op <= OP_MSUBU) begin
                    launch     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (counter == CW'(1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
            hi_next <= '0;
            lo_next <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (launch) begin
                    hi_next <= result[63:32];
                    lo_next <= result[31:0];
                    counter <= launch_cycles;
                end else if (start && md_op == OP_MTHI) begin
                    hi <= A;
                end else if (start && md_op == OP_MTLO) begin
                    lo <= A;
                end
            end else begin
                counter <= counter - CW'(1);
                if (counter == CW'(1)) begin
                    hi <= hi_next;
                    lo <= lo_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO results and busy durations.
module tb_md_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present one op for exactly one rising edge; returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        md_op = 4'd0;
        A     = 32'hDEAD_BEEF;
        B     = 32'hDEAD_BEEF;
    endtask

    // Counts negedges with busy high, bounded so a stuck busy cannot hang the run.
    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        md_op = 4'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        busy_len(n);
        check("mult_busy", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        busy_len(n);
        check("multu_busy", n, 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        busy_len(n);
        check("div_busy", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(4'd4, 32'd7, 32'd0);
        busy_len(n);
        check("divu0_busy", n, 32'd10);
        check("divu0_hi", hi, 32'hFFFF_FFFF);
        check("divu0_lo", lo, 32'hFFFF_FFFD);

        issue(4'd10, 32'd10, 32'd0);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        check("mtlo_lo", lo, 32'd10);
        issue(4'd9, 32'd0, 32'd0);
        check("mthi0_hi", hi, 32'd0);
        issue(4'd7, 32'd3, 32'd4);
        busy_len(n);
        check("msub_busy", n, 32'd5);
        check("msub_hi", hi, 32'hFFFF_FFFF);
        check("msub_lo", lo, 32'hFFFF_FFFE);
        issue(4'd6, 32'd1, 32'd2);
        busy_len(n);
        check("maddu_busy", n, 32'd5);
        check("maddu_hi", hi, 32'd0);
        check("maddu_lo", lo, 32'd0);

        issue(4'd12, 32'h1111_1111, 32'h2222_2222);
        check("op12_busy", {31'b0, busy}, 32'd0);
        check("op12_hi", hi, 32'd0);
        check("op12_lo", lo, 32'd0);

        // mtlo pulsed during busy cycle 2 must be dropped
        issue(4'd1, 32'd2, 32'd3);
        @(negedge clk);
        start = 1'b1;
        md_op = 4'd10;
        A     = 32'h55;
        @(negedge clk);
        start = 1'b0;
        md_op = 4'd0;
        check("ign_lo_mid", lo, 32'd0);
        busy_len(n);
        check("ign_busy_rest", n, 32'd3);
        check("ign_lo", lo, 32'd6);
        check("ign_hi", hi, 32'd0);

        // reset mid-divide discards the pending result
        issue(4'd9, 32'h77, 32'd0);
        check("mthi77_hi", hi, 32'h77);
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_late_busy", {31'b0, busy}, 32'd0);
        check("rst_late_hi", hi, 32'd0);
        check("rst_late_lo", lo, 32'd0);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n);
        check("divovf_busy", n, 32'd10);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        issue(4'd9, 32'h1234, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_lo_keep", lo, 32'h8000_0000);
        repeat (3) @(negedge clk);
        check("mthi_busy_later", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
